// File: rtl/down_sampler_pkg.sv
// Shared image-pipeline definitions: row-parity FSM encoding, default frame
// dimensions and a counter-width helper.
package down_sampler_pkg;

    localparam int IMG_WIDTH_DEF  = 1600;
    localparam int IMG_HEIGHT_DEF = 1200;
    localparam int PIX_W_DEF      = 8;

    typedef enum logic {
        ST_EVEN_ROW = 1'b0,
        ST_ODD_ROW  = 1'b1
    } row_state_e;

    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/ds_line_buf.sv
// Single-row pair-sum store for the averaging path: one write port and one
// registered read port whose data holds until the next read.
module ds_line_buf #(
    parameter int DEPTH  = 800,
    parameter int DATA_W = 9,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are never cleared: each entry is written on an even row
    // before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/down_sampler.sv
// 2x2 image down-sampler, one pixel per valid cycle, no backpressure.
// Define DOWN_SAMPLER_AVG_EN for 2x2 block averaging; otherwise decimates.
module down_sampler
    import down_sampler_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout,
    output logic             valid_out,
    output logic             eol_out,
    output logic             eof_out
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    row_state_e       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_col, last_row;

    logic             blk_done, blk_eol, blk_eof;
    logic [PIX_W-1:0] blk_pix;

    logic [PIX_W-1:0] dout_q;
    logic             valid_out_q, eol_q, eof_q;

    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EVEN_ROW;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (valid) begin
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d   = '0;
                    state_d = ST_EVEN_ROW;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = (state_q == ST_EVEN_ROW) ? ST_ODD_ROW : ST_EVEN_ROW;
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

`ifdef DOWN_SAMPLER_AVG_EN
    localparam int ADDR_W = COL_W - 1;
    localparam int SUM_W  = PIX_W + 2;

    logic [PIX_W-1:0] pix_a_q;
    logic             lb_wr_en, lb_rd_en;
    logic [PIX_W:0]   lb_wr_data, lb_rd_data;
    logic [SUM_W-1:0] blk_sum;

    // Left pixel of the current pair, captured on every even column.
    always_ff @(posedge clk) begin
        if (valid && !col_q[0]) begin
            pix_a_q <= din;
        end
    end

    assign lb_wr_en   = valid && (state_q == ST_EVEN_ROW) && col_q[0];
    assign lb_rd_en   = valid && (state_q == ST_ODD_ROW) && !col_q[0];
    assign lb_wr_data = (PIX_W+1)'(pix_a_q) + (PIX_W+1)'(din);

    ds_line_buf #(
        .DEPTH  (IMG_WIDTH / 2),
        .DATA_W (PIX_W + 1),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clk       (clk),
        .wr_en_i   (lb_wr_en),
        .wr_addr_i (col_q[COL_W-1:1]),
        .wr_data_i (lb_wr_data),
        .rd_en_i   (lb_rd_en),
        .rd_addr_i (col_q[COL_W-1:1]),
        .rd_data_o (lb_rd_data)
    );

    assign blk_sum = SUM_W'(lb_rd_data) + SUM_W'(pix_a_q) + SUM_W'(din) + SUM_W'(2);

    always_comb begin
        blk_done = valid && (state_q == ST_ODD_ROW) && col_q[0];
        blk_eol  = last_col;
        blk_eof  = last_col && last_row;
        blk_pix  = PIX_W'(blk_sum >> 2);
    end
`else
    localparam logic [COL_W-1:0] COL_EOL = COL_W'(IMG_WIDTH - 2);
    localparam logic [ROW_W-1:0] ROW_EOF = ROW_W'(IMG_HEIGHT - 2);

    always_comb begin
        blk_done = valid && (state_q == ST_EVEN_ROW) && !col_q[0];
        blk_eol  = (col_q == COL_EOL);
        blk_eof  = (col_q == COL_EOL) && (row_q == ROW_EOF);
        blk_pix  = din;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q      <= '0;
            valid_out_q <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            valid_out_q <= blk_done;
            eol_q       <= blk_done && blk_eol;
            eof_q       <= blk_done && blk_eof;
            if (blk_done) begin
                dout_q <= blk_pix;
            end
        end
    end

    assign dout      = dout_q;
    assign valid_out = valid_out_q;
    assign eol_out   = eol_q;
    assign eof_out   = eof_q;

endmodule

// File: tb/tb_down_sampler.sv
// Self-checking bench for down_sampler: a 4x2 instance checked pixel by pixel
// through an expected-output queue, and a 16x8 instance checked on flag counts.
module tb_down_sampler;

    localparam int W_A = 4;
    localparam int H_A = 2;
    localparam int N_A = W_A * H_A;
    localparam int W_B = 16;
    localparam int H_B = 8;
    localparam int N_B = W_B * H_B;
    localparam int OUT_PER_FRAME_B = (W_B / 2) * (H_B / 2);

    typedef struct packed {
        logic [7:0] d;
        logic       eol;
        logic       eof;
    } exp_t;

    typedef struct packed {
        logic [7:0] din;
        logic       hit;
        logic [7:0] d;
        logic       eol;
        logic       eof;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n_a, valid_a, cmp_a;
    logic [7:0] din_a, dout_a;
    logic       vo_a, eol_a, eof_a;
    logic       rst_n_b, valid_b;
    logic [7:0] din_b, dout_b;
    logic       vo_b, eol_b, eof_b;

    int checks = 0;
    int errors = 0;
    exp_t exp_q [$];
    vec_t vecs [N_A];
    logic [7:0] frm [N_A];

    int cnt_vo_b = 0, cnt_eol_b = 0, cnt_eof_b = 0, in_frame_b = 0;

    always #5 clk = ~clk;

    down_sampler #(.IMG_WIDTH(W_A), .IMG_HEIGHT(H_A), .PIX_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .valid(valid_a), .din(din_a),
        .dout(dout_a), .valid_out(vo_a), .eol_out(eol_a), .eof_out(eof_a));

    down_sampler #(.IMG_WIDTH(W_B), .IMG_HEIGHT(H_B), .PIX_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .valid(valid_b), .din(din_b),
        .dout(dout_b), .valid_out(vo_b), .eol_out(eol_b), .eof_out(eof_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour of the 4x2 instance for the pixel at raster index i.
    task automatic model(input logic [7:0] f [N_A], input int i, output logic hit, output exp_t e);
        int r, c, sum;
        r = i / W_A;
        c = i % W_A;
        e = '0;
`ifdef DOWN_SAMPLER_AVG_EN
        hit = (r % 2 == 1) && (c % 2 == 1);
        if (hit) begin
            sum = int'(f[(r-1)*W_A + c-1]) + int'(f[(r-1)*W_A + c])
                + int'(f[r*W_A + c-1]) + int'(f[i]) + 2;
            e.d   = 8'(sum >> 2);
            e.eol = (c == W_A - 1);
            e.eof = (c == W_A - 1) && (r == H_A - 1);
        end
`else
        hit = (r % 2 == 0) && (c % 2 == 0);
        if (hit) begin
            e.d   = f[i];
            e.eol = (c == W_A - 2);
            e.eof = (c == W_A - 2) && (r == H_A - 2);
        end
`endif
    endtask

    task automatic send_frame(input logic [7:0] f [N_A], input bit toggle, input int n);
        logic hit;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            model(f, i, hit, e);
            @(posedge clk); #1;
            valid_a = 1'b1;
            din_a   = f[i];
            cmp_a   = hit;
            if (hit) exp_q.push_back(e);
            if (toggle) begin
                @(posedge clk); #1;
                valid_a = 1'b0;
                cmp_a   = 1'b0;
                din_a   = 8'hA5;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_a = 1'b0;
            cmp_a   = 1'b0;
        end
    endtask

    // Instance A monitor: valid_out must follow each completing input by one cycle.
    bit         due_a = 1'b0;
    bit         rst_seen_a = 1'b1;
    logic [7:0] last_d_a = 8'd0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen_a) last_d_a = 8'd0;
        chk("a_valid_out", vo_a, due_a);
        if (vo_a === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("a_unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("a_dout", dout_a, e.d);
                chk("a_eol", eol_a, e.eol);
                chk("a_eof", eof_a, e.eof);
                last_d_a = e.d;
            end
        end else begin
            chk("a_dout_hold", dout_a, last_d_a);
            chk("a_eol_idle", eol_a, 0);
            chk("a_eof_idle", eof_a, 0);
        end
        due_a      = (valid_a === 1'b1) && (cmp_a === 1'b1) && (rst_n_a === 1'b1);
        rst_seen_a = (rst_n_a !== 1'b1);
    end

    always @(negedge clk) begin
        if (rst_n_b === 1'b1 && vo_b === 1'b1) begin
            cnt_vo_b++;
            in_frame_b++;
            if (eol_b === 1'b1) begin
                cnt_eol_b++;
                chk("b_eol_position", in_frame_b % (W_B / 2), 0);
            end
            if (eof_b === 1'b1) begin
                cnt_eof_b++;
                chk("b_eof_position", in_frame_b, OUT_PER_FRAME_B);
                chk("b_eof_with_eol", eol_b, 1);
                in_frame_b = 0;
            end
        end
    end

    initial begin
        rst_n_a = 1'b0; valid_a = 1'b0; din_a = 8'd0; cmp_a = 1'b0;
        rst_n_b = 1'b0; valid_b = 1'b0; din_b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        idle(2);

        // Ramp 0..7 on a 4x2 frame with hand-computed expectations.
        for (int i = 0; i < N_A; i++) vecs[i] = '{din: 8'(i), hit: 1'b0, d: 8'd0, eol: 1'b0, eof: 1'b0};
`ifdef DOWN_SAMPLER_AVG_EN
        vecs[5].hit = 1'b1; vecs[5].d = 8'd3;
        vecs[7].hit = 1'b1; vecs[7].d = 8'd5; vecs[7].eol = 1'b1; vecs[7].eof = 1'b1;
`else
        vecs[0].hit = 1'b1; vecs[0].d = 8'd0;
        vecs[2].hit = 1'b1; vecs[2].d = 8'd2; vecs[2].eol = 1'b1; vecs[2].eof = 1'b1;
`endif
        for (int i = 0; i < N_A; i++) begin
            @(posedge clk); #1;
            valid_a = 1'b1;
            din_a   = vecs[i].din;
            cmp_a   = vecs[i].hit;
            if (vecs[i].hit) exp_q.push_back('{d: vecs[i].d, eol: vecs[i].eol, eof: vecs[i].eof});
        end
        idle(3);

        for (int i = 0; i < N_A; i++) frm[i] = 8'd255;
        send_frame(frm, 1'b0, N_A);
        idle(2);

        for (int i = 0; i < N_A; i++) frm[i] = 8'(i);
        send_frame(frm, 1'b1, N_A);
        idle(2);

        repeat (4) begin
            for (int i = 0; i < N_A; i++) frm[i] = 8'($urandom_range(0, 255));
            send_frame(frm, 1'b0, N_A);
        end
        idle(2);

        // Reset after five pixels; the next frame must start fresh at (0,0).
        for (int i = 0; i < N_A; i++) frm[i] = 8'(200 + i);
        send_frame(frm, 1'b0, 5);
        @(posedge clk); #1;
        valid_a = 1'b0;
        cmp_a   = 1'b0;
        rst_n_a = 1'b0;
        @(posedge clk); #1;
        rst_n_a = 1'b1;
        for (int i = 0; i < N_A; i++) frm[i] = 8'(i * 30 + 7);
        send_frame(frm, 1'b0, N_A);
        idle(3);

        for (int i = 0; i < 2 * N_B; i++) begin
            @(posedge clk); #1;
            valid_b = 1'b1;
            din_b   = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #1;
        valid_b = 1'b0;
        idle(4);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        chk("a_queue_drained", exp_q.size(), 0);
        chk("b_valid_out_count", cnt_vo_b, 2 * OUT_PER_FRAME_B);
        chk("b_eol_count", cnt_eol_b, 2 * (H_B / 2));
        chk("b_eof_count", cnt_eof_b, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
